// File: rtl/ccip_avmm_mmio_rsp_gen.sv
// MMIO read return path: tracks accepted reads in order and turns each Avalon
// readdatavalid beat into a single-cycle CCI-P C2 MMIO read response.
module ccip_avmm_mmio_rsp_gen #(
   parameter int MAX_OUTSTANDING = 64,
   parameter int TID_WIDTH       = 9,
   parameter int ADDR_WIDTH      = 18,
   parameter int DATA_WIDTH      = 64
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic                               cmd_is_read,
   input  logic                               cmd_is_32bit,
   input  logic [ADDR_WIDTH-1:0]              cmd_addr,
   input  logic [TID_WIDTH-1:0]               cmd_tid,
   input  logic [DATA_WIDTH-1:0]              avm_readdata,
   input  logic                               avm_readdatavalid,
   output logic                               c2_rsp_valid,
   output logic [TID_WIDTH-1:0]               c2_rsp_tid,
   output logic [DATA_WIDTH-1:0]              c2_rsp_data,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               err_unexpected_rsp
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;
   localparam int EW = TID_WIDTH + 2;

   // A 32-bit read returns the addressed word replicated into both halves.
   function automatic logic [DATA_WIDTH-1:0] f_sel_data(
      input logic                  is32,
      input logic                  a2,
      input logic [DATA_WIDTH-1:0] d
   );
      if (!is32)
         f_sel_data = d;
      else if (a2)
         f_sel_data = {d[63:32], d[63:32]};
      else
         f_sel_data = {d[31:0], d[31:0]};
   endfunction

   logic [EW-1:0]         r_mem [MAX_OUTSTANDING];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_cnt;
   logic                  r_cmd_ready;
   logic                  r_rsp_valid;
   logic [TID_WIDTH-1:0]  r_rsp_tid;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_err;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_unexp;
   logic [CW-1:0]         w_cnt_nxt;
   logic [EW-1:0]         w_entry;
   logic [EW-1:0]         w_head;
   logic                  w_unused;

   assign w_push    = cmd_valid && r_cmd_ready && cmd_is_read;
   assign w_pop     = avm_readdatavalid && (r_cnt != '0);
   assign w_unexp   = avm_readdatavalid && (r_cnt == '0);
   assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
   assign w_entry   = {cmd_tid, cmd_is_32bit, cmd_addr[2]};
   assign w_head    = r_mem[r_rptr];
   assign w_unused  = ^{cmd_addr[ADDR_WIDTH-1:3], cmd_addr[1:0]};

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= w_entry;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_tid   <= '0;
         r_rsp_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         r_cnt       <= w_cnt_nxt;
         // Ready is computed from the post-edge count so a pop at full frees a slot next cycle.
         r_cmd_ready <= (w_cnt_nxt < CW'(MAX_OUTSTANDING));
         r_rsp_valid <= w_pop;
         if (w_pop) begin
            r_rsp_tid  <= w_head[EW-1:2];
            r_rsp_data <= f_sel_data(w_head[1], w_head[0], avm_readdata);
         end
         if (w_unexp)
            r_err <= 1'b1;
      end
   end

   assign cmd_ready          = r_cmd_ready;
   assign c2_rsp_valid       = r_rsp_valid;
   assign c2_rsp_tid         = r_rsp_tid;
   assign c2_rsp_data        = r_rsp_data;
   assign outstanding        = r_cnt;
   assign err_unexpected_rsp = r_err;

endmodule

// File: tb/tb_ccip_avmm_mmio_rsp_gen.sv
// Bench for ccip_avmm_mmio_rsp_gen: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ccip_avmm_mmio_rsp_gen;

   localparam int MAXO = 64;
   localparam int TW   = 9;
   localparam int AW   = 18;
   localparam int DW   = 64;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_is_read = 1'b0;
   logic          cmd_is_32bit = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [TW-1:0] cmd_tid = '0;
   logic [DW-1:0] avm_readdata = '0;
   logic          avm_readdatavalid = 1'b0;
   logic          c2_rsp_valid;
   logic [TW-1:0] c2_rsp_tid;
   logic [DW-1:0] c2_rsp_data;
   logic [6:0]    outstanding;
   logic          err_unexpected_rsp;

   ccip_avmm_mmio_rsp_gen #(
      .MAX_OUTSTANDING(MAXO), .TID_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_is_read(cmd_is_read), .cmd_is_32bit(cmd_is_32bit),
      .cmd_addr(cmd_addr), .cmd_tid(cmd_tid),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .c2_rsp_valid(c2_rsp_valid), .c2_rsp_tid(c2_rsp_tid), .c2_rsp_data(c2_rsp_data),
      .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of outstanding reads plus the expected outputs.
   typedef struct {
      logic [TW-1:0] tid;
      bit            is32;
      bit            a2;
   } ent_t;

   ent_t          q[$];
   bit            m_ready;
   bit            m_valid;
   logic [TW-1:0] m_tid;
   logic [DW-1:0] m_data;
   bit            m_err;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_ready = 0;
         m_valid = 0;
         m_tid   = '0;
         m_data  = '0;
         m_err   = 0;
      end else begin
         ent_t e;
         bit   acc;
         acc     = cmd_valid && m_ready;
         m_valid = 0;
         if (avm_readdatavalid) begin
            if (q.size() == 0) begin
               m_err = 1;
            end else begin
               e       = q.pop_front();
               m_valid = 1;
               m_tid   = e.tid;
               if (!e.is32)   m_data = avm_readdata;
               else if (e.a2) m_data = {2{avm_readdata[63:32]}};
               else           m_data = {2{avm_readdata[31:0]}};
            end
         end
         if (acc && cmd_is_read) begin
            e.tid  = cmd_tid;
            e.is32 = cmd_is_32bit;
            e.a2   = cmd_addr[2];
            q.push_back(e);
         end
         m_ready = (q.size() < MAXO);
      end
   end

   always @(negedge clk) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
      chk("rsp_valid", 64'(c2_rsp_valid), 64'(m_valid));
      chk("rsp_tid", 64'(c2_rsp_tid), 64'(m_tid));
      chk("rsp_data", c2_rsp_data, m_data);
      chk("outstanding", 64'(outstanding), 64'(q.size()));
      chk("err", 64'(err_unexpected_rsp), 64'(m_err));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input bit rd, input bit is32, input logic [AW-1:0] a, input logic [TW-1:0] t);
      cmd_valid    = 1'b1;
      cmd_is_read  = rd;
      cmd_is_32bit = is32;
      cmd_addr     = a;
      cmd_tid      = t;
      tick();
      cmd_valid    = 1'b0;
   endtask

   task automatic beat(input logic [DW-1:0] d);
      avm_readdatavalid = 1'b1;
      avm_readdata      = d;
      tick();
      avm_readdatavalid = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      reset_n = 1'b1;
      chk("ready_before_edge", 64'(cmd_ready), 64'd0);
      tick();
      chk("ready_after_release", 64'(cmd_ready), 64'd1);

      // Basic 64-bit read
      send_cmd(1, 0, 18'h01000, 9'h0A5);
      chk("out_one", 64'(outstanding), 64'd1);
      tick();
      tick();
      beat(64'h1122334455667788);
      chk("t1_valid", 64'(c2_rsp_valid), 64'd1);
      chk("t1_tid", 64'(c2_rsp_tid), 64'h0A5);
      chk("t1_data", c2_rsp_data, 64'h1122334455667788);
      chk("t1_out", 64'(outstanding), 64'd0);
      tick();
      chk("t1_pulse", 64'(c2_rsp_valid), 64'd0);
      chk("t1_hold", c2_rsp_data, 64'h1122334455667788);

      // 32-bit reads, upper then lower word
      send_cmd(1, 1, 18'h00004, 9'h003);
      beat(64'hAAAABBBB_CCCCDDDD);
      chk("t2_hi", c2_rsp_data, 64'hAAAABBBB_AAAABBBB);
      send_cmd(1, 1, 18'h00000, 9'h003);
      beat(64'hAAAABBBB_CCCCDDDD);
      chk("t2_lo", c2_rsp_data, 64'hCCCCDDDD_CCCCDDDD);

      // Fill the tracker
      for (int i = 0; i < 64; i++) send_cmd(1, 0, 18'($urandom), 9'(i));
      chk("full_ready", 64'(cmd_ready), 64'd0);
      chk("full_out", 64'(outstanding), 64'd64);
      cmd_valid = 1'b1; cmd_is_read = 1'b0; cmd_tid = 9'h1FF;
      tick();
      tick();
      chk("full_stall", 64'(outstanding), 64'd64);
      avm_readdatavalid = 1'b1;
      avm_readdata      = 64'h0;
      tick();
      avm_readdatavalid = 1'b0;
      chk("full_tid0", 64'(c2_rsp_tid), 64'd0);
      chk("full_reready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      for (int i = 1; i < 64; i++) begin
         beat(64'($urandom) << 32 | 64'($urandom));
         chk("drain_tid", 64'(c2_rsp_tid), 64'(i));
      end
      chk("drain_out", 64'(outstanding), 64'd0);

      // Steady state push+pop
      send_cmd(1, 0, 18'h0, 9'd100);
      for (int k = 0; k < 10; k++) begin
         cmd_valid = 1'b1; cmd_is_read = 1'b1; cmd_is_32bit = 1'b0;
         cmd_tid = 9'(101 + k);
         avm_readdatavalid = 1'b1;
         avm_readdata = 64'(k);
         tick();
         chk("ss_out", 64'(outstanding), 64'd1);
         chk("ss_tid", 64'(c2_rsp_tid), 64'(100 + k));
      end
      cmd_valid = 1'b0;
      avm_readdatavalid = 1'b0;
      beat(64'h5);
      chk("ss_last", 64'(c2_rsp_tid), 64'd110);

      // Unexpected beat and writes only
      chk("err_clear", 64'(err_unexpected_rsp), 64'd0);
      beat(64'hDEAD);
      chk("unexp_valid", 64'(c2_rsp_valid), 64'd0);
      chk("unexp_err", 64'(err_unexpected_rsp), 64'd1);
      for (int k = 0; k < 5; k++) begin
         send_cmd(0, 0, 18'($urandom), 9'($urandom));
         chk("wr_out", 64'(outstanding), 64'd0);
         chk("wr_valid", 64'(c2_rsp_valid), 64'd0);
      end
      chk("err_sticky", 64'(err_unexpected_rsp), 64'd1);

      // Reset mid-stream
      for (int k = 0; k < 5; k++) send_cmd(1, 0, 18'h0, 9'(200 + k));
      beat(64'hFFFF_0000_FFFF_0000);
      send_cmd(1, 0, 18'h0, 9'd210);
      reset_n = 1'b0;
      #1;
      chk("rst_valid", 64'(c2_rsp_valid), 64'd0);
      chk("rst_tid", 64'(c2_rsp_tid), 64'd0);
      chk("rst_data", c2_rsp_data, 64'd0);
      chk("rst_out", 64'(outstanding), 64'd0);
      chk("rst_err", 64'(err_unexpected_rsp), 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      beat(64'h1);
      beat(64'h2);
      chk("late_valid", 64'(c2_rsp_valid), 64'd0);
      chk("late_err", 64'(err_unexpected_rsp), 64'd1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cmd_valid         = ($urandom_range(0, 99) < 50);
         cmd_is_read       = ($urandom_range(0, 99) < 80);
         cmd_is_32bit      = 1'($urandom);
         cmd_addr          = 18'($urandom);
         cmd_tid           = 9'($urandom);
         avm_readdata      = {32'($urandom), 32'($urandom)};
         avm_readdatavalid = (q.size() != 0) ? ($urandom_range(0, 99) < 45)
                                             : ($urandom_range(0, 99) < 3);
         tick();
      end
      cmd_valid = 1'b0;
      for (int n = 0; n < 80; n++) begin
         avm_readdatavalid = (q.size() != 0);
         avm_readdata      = {32'($urandom), 32'($urandom)};
         tick();
      end
      avm_readdatavalid = 1'b0;
      tick();
      chk("final_out", 64'(outstanding), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ccip_avmm_mmio_rsp_gen.md
Name: ccip_avmm_mmio_rsp_gen

Overview:
- Return path of the CCI-P-to-Avalon MMIO bridge.
- Records every accepted MMIO read command (CCI-P tid, 32/64-bit size, address bit 2) in an in-order tracking FIFO.
- Pairs each Avalon readdatavalid beat with the oldest outstanding read and emits a CCI-P C2 MMIO read response.
- Sits between the MMIO command decoder / Avalon master and the C2 Tx port.

Parameters:
- MAX_OUTSTANDING, 64, tracking FIFO depth; must be a power of 2 and at least 2.
- TID_WIDTH, 9, CCI-P MMIO transaction ID width.
- ADDR_WIDTH, 18, Avalon byte address width of the command.
- DATA_WIDTH, 64, MMIO data width; fixed at 64.

Ports:
- clk  in  1  bridge clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  MMIO command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_is_read  in  1  1 = read, 0 = write
- cmd_is_32bit  in  1  1 = 32-bit access
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_tid  in  TID_WIDTH  CCI-P tid of the request
- avm_readdata  in  DATA_WIDTH  Avalon read data
- avm_readdatavalid  in  1  Avalon read data beat (in order, no backpressure)
- c2_rsp_valid  out  1  C2 MMIO response valid (single-cycle pulse)
- c2_rsp_tid  out  TID_WIDTH  response tid
- c2_rsp_data  out  DATA_WIDTH  response data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
- err_unexpected_rsp  out  1  sticky: readdatavalid arrived with tracker empty

Behaviour:
- Reset (reset_n low, asynchronous):
  - c2_rsp_valid=0, c2_rsp_tid=0, c2_rsp_data=0, outstanding=0, err_unexpected_rsp=0.
  - FIFO pointers cleared.
  - cmd_ready=0 while reset_n is low; cmd_ready=1 from the first clk edge after release.
  - Reset mid-operation discards all tracked reads; late readdatavalid beats after reset raise err_unexpected_rsp.
- cmd_ready:
  - Registered; equals (outstanding < MAX_OUTSTANDING) using the next-state count.
  - Never a combinational function of cmd_valid.
  - Applies to reads and writes alike so that command order is preserved.
- Push: on accept with cmd_is_read=1, write {cmd_tid, cmd_is_32bit, cmd_addr[2]} at the write pointer.
- Accepted writes: produce no FIFO entry and no response.
- Pop: on avm_readdatavalid with outstanding>0, read the head entry and advance the read pointer.
- Registered response (1-cycle latency): on the clk edge following the beat, c2_rsp_valid=1, c2_rsp_tid=head tid, and c2_rsp_data selected as follows:
  - 64-bit entry: avm_readdata unmodified.
  - 32-bit entry, addr[2]=0: {readdata[31:0], readdata[31:0]}.
  - 32-bit entry, addr[2]=1: {readdata[63:32], readdata[63:32]}.
- Response pulse:
  - c2_rsp_valid is high exactly one cycle per matched beat.
  - Back-to-back beats give back-to-back responses.
  - c2_rsp_tid and c2_rsp_data hold their last value when valid is low.
- Unexpected beat: avm_readdatavalid with outstanding==0, evaluated on pre-edge state.
  - Beat dropped, no response.
  - err_unexpected_rsp set; it clears only on reset.
- Simultaneous push and pop:
  - outstanding unchanged; both pointers advance.
  - The pop returns the pre-existing head, never the entry pushed in the same cycle.
- Full: outstanding==MAX_OUTSTANDING forces cmd_ready=0.
  - A pop in that cycle re-asserts cmd_ready on the next cycle.
- Pointers: $clog2(MAX_OUTSTANDING) bits, natural wrap-around.
- outstanding: updated +1 on push, −1 on pop, net 0 on both; never exceeds MAX_OUTSTANDING and never underflows.

Test Plan:
- Reset release, then read tid=0x0A5, 64-bit, addr=0x1000, followed 3 cycles later by readdata=0x1122334455667788 -> one cycle later c2_rsp_valid=1, tid=0x0A5, data=0x1122334455667788; outstanding 1->0.
- 32-bit read addr=0x0004 tid=0x003 with readdata=0xAAAABBBB_CCCCDDDD -> data=0xAAAABBBB_AAAABBBB; repeat with addr=0x0000 -> data=0xCCCCDDDD_CCCCDDDD.
- 64 reads, tids 0..63, no responses -> cmd_ready=0 after the 64th accept and a write command stalls; one readdatavalid -> tid 0 returned and cmd_ready=1 the next cycle; then 63 more beats -> tids 1..63 in order, outstanding=0.
- Steady state: cmd accept and readdatavalid in the same cycle for 10 cycles -> outstanding constant, tids returned strictly in push order.
- readdatavalid with tracker empty -> no c2_rsp_valid, err_unexpected_rsp=1 and sticky; writes only (cmd_is_read=0) -> no responses, outstanding stays 0.
- 5 reads outstanding, assert reset_n low mid-stream -> all outputs 0 immediately; after release, 2 late beats -> no responses, err_unexpected_rsp=1.
